// File: rtl/cluster_responder_pkg.sv
// Shared encodings, FSM states and default narrow AXI4 channel structs for the cluster responder.
package cluster_responder_pkg;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic       {RIdle, RData}        r_state_e;

  typedef struct packed {
    logic [1:0]  id;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic        user;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } w_chan_t;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] resp;
    logic       user;
  } b_chan_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [47:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic        user;
  } ar_chan_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } narrow_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } narrow_resp_t;

endpackage

// File: rtl/cluster_narrow_responder_if.sv
// Narrow AXI4 request/response bundle between the cluster master port and the responder.
interface cluster_narrow_responder_if;
  import cluster_responder_pkg::*;

  narrow_req_t  req;
  narrow_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/cluster_responder_addr_gen.sv
// Next beat address and beat count: INCR steps one data word, FIXED and WRAP hold the address.
module cluster_responder_addr_gen
  import cluster_responder_pkg::*;
#(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [1:0]           burst_i,
  input  logic [7:0]           cnt_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic [7:0]           cnt_o
);

  always_comb begin
    addr_o = addr_i;
    if (burst_i == BurstIncr) begin
      addr_o = addr_i + AddrWidth'(DataWidth / 8);
    end
  end

  assign cnt_o = cnt_i + 8'd1;

endmodule

// File: rtl/cluster_narrow_responder.sv
// AXI4 subordinate backed by a flip-flop memory at base 0, with independent read and write FSMs.
module cluster_narrow_responder
  import cluster_responder_pkg::*;
#(
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned IdWidth    = 2,
  parameter int unsigned NumWords   = 256,
  parameter type         axi_req_t  = narrow_req_t,
  parameter type         axi_resp_t = narrow_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  axi_req_i,
  output axi_resp_t axi_resp_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffWidth  = $clog2(StrbWidth);
  localparam int unsigned IdxWidth  = $clog2(NumWords);

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [IdxWidth-1:0]  idx_t;

  // Window base is 0, so any set bit above the word index is out of range.
  function automatic logic out_of_range(addr_t a);
    return |a[AddrWidth-1:OffWidth+IdxWidth];
  endfunction

  function automatic idx_t word_idx(addr_t a);
    return a[OffWidth +: IdxWidth];
  endfunction

  logic [DataWidth-1:0] mem_q [NumWords];

  // Write channel state
  w_state_e           w_state_q;
  logic               aw_ready_q, w_ready_q, b_valid_q;
  logic [IdWidth-1:0] b_id_q;
  logic [1:0]         b_resp_q;
  addr_t              w_addr_q, w_addr_nxt;
  logic [7:0]         w_len_q, w_cnt_q, w_cnt_nxt;
  logic [1:0]         w_burst_q;
  logic               w_err_q;
  logic               w_beat, w_beat_oor, mem_we;

  // Read channel state
  r_state_e             r_state_q;
  logic                 ar_ready_q, r_valid_q, r_last_q;
  logic [IdWidth-1:0]   r_id_q;
  logic [DataWidth-1:0] r_data_q;
  logic [1:0]           r_resp_q;
  addr_t                r_addr_q, r_addr_nxt, rd_addr;
  logic [7:0]           r_len_q, r_cnt_q, r_cnt_nxt;
  logic [1:0]           r_burst_q, rd_burst;
  logic                 rd_err;
  logic [DataWidth-1:0] rd_data;

  logic unused_req;
  assign unused_req = ^axi_req_i;

  cluster_responder_addr_gen #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth)
  ) u_w_addr_gen (
    .addr_i  (w_addr_q),
    .burst_i (w_burst_q),
    .cnt_i   (w_cnt_q),
    .addr_o  (w_addr_nxt),
    .cnt_o   (w_cnt_nxt)
  );

  cluster_responder_addr_gen #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth)
  ) u_r_addr_gen (
    .addr_i  (r_addr_q),
    .burst_i (r_burst_q),
    .cnt_i   (r_cnt_q),
    .addr_o  (r_addr_nxt),
    .cnt_o   (r_cnt_nxt)
  );

  assign w_beat     = w_ready_q & axi_req_i.w_valid;
  assign w_beat_oor = out_of_range(w_addr_q);
  assign mem_we     = w_beat & (w_burst_q != BurstWrap) & ~w_beat_oor;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (axi_req_i.w.strb[b]) mem_q[word_idx(w_addr_q)][b*8 +: 8] <= axi_req_i.w.data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q  <= WIdle;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= RespOkay;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_cnt_q    <= '0;
      w_burst_q  <= BurstFixed;
      w_err_q    <= 1'b0;
    end else begin
      unique case (w_state_q)
        WIdle: begin
          if (aw_ready_q && axi_req_i.aw_valid) begin
            b_id_q     <= axi_req_i.aw.id;
            w_addr_q   <= axi_req_i.aw.addr;
            w_len_q    <= axi_req_i.aw.len;
            w_burst_q  <= axi_req_i.aw.burst;
            w_cnt_q    <= '0;
            w_err_q    <= (axi_req_i.aw.burst == BurstWrap);
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            w_state_q  <= WData;
          end else begin
            aw_ready_q <= 1'b1;
          end
        end
        WData: begin
          if (w_beat) begin
            w_addr_q <= w_addr_nxt;
            w_cnt_q  <= w_cnt_nxt;
            w_err_q  <= w_err_q | w_beat_oor;
            if (axi_req_i.w.last) begin
              // A beat count mismatch at wlast is a protocol error reported on B.
              b_resp_q  <= (w_err_q || w_beat_oor || (w_cnt_q != w_len_q)) ? RespSlvErr : RespOkay;
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              w_state_q <= WResp;
            end
          end
        end
        WResp: begin
          if (axi_req_i.b_ready) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_state_q  <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  // Beat to fetch this cycle: the AR address when idle, the following beat when streaming.
  always_comb begin
    rd_addr  = axi_req_i.ar.addr;
    rd_burst = axi_req_i.ar.burst;
    if (r_state_q == RData) begin
      rd_addr  = r_addr_nxt;
      rd_burst = r_burst_q;
    end
    rd_err  = out_of_range(rd_addr) || (rd_burst == BurstWrap);
    rd_data = rd_err ? '0 : mem_q[word_idx(rd_addr)];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q  <= RIdle;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
      r_data_q   <= '0;
      r_resp_q   <= RespOkay;
      r_addr_q   <= '0;
      r_len_q    <= '0;
      r_cnt_q    <= '0;
      r_burst_q  <= BurstFixed;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (ar_ready_q && axi_req_i.ar_valid) begin
            r_id_q     <= axi_req_i.ar.id;
            r_addr_q   <= axi_req_i.ar.addr;
            r_len_q    <= axi_req_i.ar.len;
            r_burst_q  <= axi_req_i.ar.burst;
            r_cnt_q    <= '0;
            r_data_q   <= rd_data;
            r_resp_q   <= rd_err ? RespSlvErr : RespOkay;
            r_last_q   <= (axi_req_i.ar.len == 8'd0);
            r_valid_q  <= 1'b1;
            ar_ready_q <= 1'b0;
            r_state_q  <= RData;
          end else begin
            ar_ready_q <= 1'b1;
          end
        end
        RData: begin
          if (axi_req_i.r_ready) begin
            if (r_last_q) begin
              r_valid_q  <= 1'b0;
              r_last_q   <= 1'b0;
              ar_ready_q <= 1'b1;
              r_state_q  <= RIdle;
            end else begin
              r_addr_q <= r_addr_nxt;
              r_cnt_q  <= r_cnt_nxt;
              r_data_q <= rd_data;
              r_resp_q <= rd_err ? RespSlvErr : RespOkay;
              r_last_q <= (r_cnt_nxt == r_len_q);
            end
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_ready_q;
    axi_resp_o.w_ready  = w_ready_q;
    axi_resp_o.b_valid  = b_valid_q;
    axi_resp_o.b.id     = b_id_q;
    axi_resp_o.b.resp   = b_resp_q;
    axi_resp_o.ar_ready = ar_ready_q;
    axi_resp_o.r_valid  = r_valid_q;
    axi_resp_o.r.id     = r_id_q;
    axi_resp_o.r.data   = r_data_q;
    axi_resp_o.r.resp   = r_resp_q;
    axi_resp_o.r.last   = r_last_q;
  end

endmodule

// File: tb/tb_cluster_narrow_responder.sv
// Randomised and directed bench for cluster_narrow_responder against a byte-addressed memory model.
module tb_cluster_narrow_responder;
  import cluster_responder_pkg::*;

  localparam int MemBytes = 2048;
  localparam int Timeout  = 50;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [7:0]  mdl [MemBytes];
  logic [63:0] wd  [256];
  logic [7:0]  ws  [256];

  cluster_narrow_responder_if bus ();

  cluster_narrow_responder dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .axi_req_i  (bus.req),
    .axi_resp_o (bus.resp)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int beat_addr(input int base, input logic [1:0] burst, input int k);
    return (burst == BurstIncr) ? base + 8 * k : base;
  endfunction

  function automatic logic [63:0] mdl_word(input int a);
    logic [63:0] w = '0;
    if (a < MemBytes) for (int b = 0; b < 8; b++) w[b*8 +: 8] = mdl[a - (a % 8) + b];
    return w;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < MemBytes; i++) mdl[i] = 8'h00;
  endtask

  // Write burst of nbeats beats taken from wd/ws; nbeats < len+1 exercises an early wlast.
  task automatic axi_write(input logic [1:0] id, input int addr, input int len,
                           input logic [1:0] burst, input int nbeats, input logic gaps);
    int t, a;
    logic err;
    @(negedge clk_i);
    bus.req.aw       = '0;
    bus.req.aw.id    = id;
    bus.req.aw.addr  = 48'(addr);
    bus.req.aw.len   = 8'(len);
    bus.req.aw.size  = 3'd3;
    bus.req.aw.burst = burst;
    bus.req.aw_valid = 1'b1;
    t = 0;
    while (!bus.resp.aw_ready && t < Timeout) begin @(negedge clk_i); t++; end
    if (t >= Timeout) check_eq("aw_timeout", 64'(t), 64'(0));
    @(negedge clk_i);
    bus.req.aw_valid = 1'b0;
    check_eq("aw_ready_busy", 64'(bus.resp.aw_ready), 64'(0));
    err = (burst == BurstWrap) || (nbeats != len + 1);
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        bus.req.w_valid = 1'b0;
        @(negedge clk_i);
      end
      bus.req.w.data  = wd[i];
      bus.req.w.strb  = ws[i];
      bus.req.w.last  = (i == nbeats - 1);
      bus.req.w_valid = 1'b1;
      t = 0;
      while (!bus.resp.w_ready && t < Timeout) begin @(negedge clk_i); t++; end
      if (t >= Timeout) check_eq("w_timeout", 64'(t), 64'(0));
      a = beat_addr(addr, burst, i);
      if (a >= MemBytes) err = 1'b1;
      else if (burst != BurstWrap)
        for (int b = 0; b < 8; b++) if (ws[i][b]) mdl[a - (a % 8) + b] = wd[i][b*8 +: 8];
      @(negedge clk_i);
    end
    bus.req.w_valid = 1'b0;
    bus.req.w.last  = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk_i);
    bus.req.b_ready = 1'b1;
    t = 0;
    while (!bus.resp.b_valid && t < Timeout) begin @(negedge clk_i); t++; end
    if (t >= Timeout) check_eq("b_timeout", 64'(t), 64'(0));
    check_eq("b_resp", 64'(bus.resp.b.resp), 64'(err ? 2'b10 : 2'b00));
    check_eq("b_id", 64'(bus.resp.b.id), 64'(id));
    @(negedge clk_i);
    bus.req.b_ready = 1'b0;
  endtask

  // mode 0: r_ready always high, 1: toggles starting low, 2: random
  task automatic axi_read(input logic [1:0] id, input int addr, input int len,
                          input logic [1:0] burst, input int mode, output logic [63:0] first);
    int t, k, cyc, a;
    logic rdy;
    first = '0;
    @(negedge clk_i);
    bus.req.ar       = '0;
    bus.req.ar.id    = id;
    bus.req.ar.addr  = 48'(addr);
    bus.req.ar.len   = 8'(len);
    bus.req.ar.size  = 3'd3;
    bus.req.ar.burst = burst;
    bus.req.ar_valid = 1'b1;
    t = 0;
    while (!bus.resp.ar_ready && t < Timeout) begin @(negedge clk_i); t++; end
    if (t >= Timeout) check_eq("ar_timeout", 64'(t), 64'(0));
    @(negedge clk_i);
    bus.req.ar_valid = 1'b0;
    k = 0;
    cyc = 0;
    while (k <= len && cyc < (len + 1) * 4 + Timeout) begin
      a = beat_addr(addr, burst, k);
      check_eq("r_valid", 64'(bus.resp.r_valid), 64'(1));
      check_eq("r_data", bus.resp.r.data, mdl_word(a));
      check_eq("r_resp", 64'(bus.resp.r.resp), 64'(a >= MemBytes ? 2'b10 : 2'b00));
      check_eq("r_last", 64'(bus.resp.r.last), 64'(k == len));
      check_eq("r_id", 64'(bus.resp.r.id), 64'(id));
      check_eq("ar_ready_busy", 64'(bus.resp.ar_ready), 64'(0));
      if (k == 0) first = bus.resp.r.data;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      bus.req.r_ready = rdy;
      @(negedge clk_i);
      if (rdy) k++;
      cyc++;
    end
    if (k <= len) check_eq("r_beats", 64'(k), 64'(len + 1));
    bus.req.r_ready = 1'b0;
    check_eq("r_done", 64'(bus.resp.r_valid), 64'(0));
  endtask

  initial begin
    logic [63:0] rd;
    int t, len, nb, addr;
    logic [1:0] burst;

    bus.req = '0;
    mdl_clear();
    repeat (2) @(negedge clk_i);
    check_eq("rst_aw_ready", 64'(bus.resp.aw_ready), 64'(0));
    check_eq("rst_ar_ready", 64'(bus.resp.ar_ready), 64'(0));
    check_eq("rst_w_ready", 64'(bus.resp.w_ready), 64'(0));
    check_eq("rst_b_valid", 64'(bus.resp.b_valid), 64'(0));
    check_eq("rst_r_valid", 64'(bus.resp.r_valid), 64'(0));
    check_eq("rst_r_data", bus.resp.r.data, 64'(0));
    rst_ni = 1'b1;

    // Single-beat write/read round trip
    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    axi_write(2'd1, 'h10, 0, BurstIncr, 1, 1'b0);
    axi_read(2'd2, 'h10, 0, BurstIncr, 0, rd);
    check_eq("single_rd", rd, 64'h1122334455667788);

    // Four-beat INCR, read back under r_ready toggling
    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
    axi_write(2'd3, 'h0, 3, BurstIncr, 4, 1'b1);
    axi_read(2'd1, 'h0, 3, BurstIncr, 1, rd);

    // Byte strobes
    wd[0] = 64'h0; ws[0] = 8'hFF;
    axi_write(2'd0, 'h20, 0, BurstIncr, 1, 1'b0);
    wd[0] = 64'hFFFFFFFFFFFFFFFF; ws[0] = 8'h0F;
    axi_write(2'd0, 'h20, 0, BurstIncr, 1, 1'b0);
    axi_read(2'd0, 'h20, 0, BurstIncr, 0, rd);
    check_eq("strb_rd", rd, 64'h00000000FFFFFFFF);

    // Out of range just past the window; word 0 must be untouched
    wd[0] = 64'hDEADBEEFCAFEF00D; ws[0] = 8'hFF;
    axi_write(2'd2, 'h800, 0, BurstIncr, 1, 1'b0);
    axi_read(2'd2, 'h800, 0, BurstIncr, 0, rd);
    check_eq("oor_rd", rd, 64'h0);
    axi_read(2'd0, 'h0, 0, BurstIncr, 0, rd);
    check_eq("oor_no_alias", rd, 64'h1);

    // WRAP is refused; FIXED keeps only the last beat
    for (int i = 0; i < 4; i++) begin wd[i] = 64'hA5A5_0000 + 64'(i); ws[i] = 8'hFF; end
    axi_write(2'd1, 'h40, 3, BurstWrap, 4, 1'b1);
    axi_read(2'd1, 'h40, 0, BurstIncr, 0, rd);
    check_eq("wrap_no_write", rd, 64'h0);
    wd[0] = 64'hAAAA; wd[1] = 64'hBBBB; wd[2] = 64'hCCCC;
    axi_write(2'd2, 'h8, 2, BurstFixed, 3, 1'b0);
    axi_read(2'd2, 'h8, 0, BurstIncr, 0, rd);
    check_eq("fixed_last", rd, 64'hCCCC);

    // Early wlast
    wd[0] = 64'h77; ws[0] = 8'hFF;
    axi_write(2'd3, 'h60, 2, BurstIncr, 1, 1'b0);

    // Maximum-length read
    axi_read(2'd3, 'h0, 255, BurstIncr, 0, rd);

    // Reset in the middle of a len-7 read
    @(negedge clk_i);
    bus.req.ar       = '0;
    bus.req.ar.len   = 8'd7;
    bus.req.ar.burst = BurstIncr;
    bus.req.ar_valid = 1'b1;
    t = 0;
    while (!bus.resp.ar_ready && t < Timeout) begin @(negedge clk_i); t++; end
    if (t >= Timeout) check_eq("ar_timeout", 64'(t), 64'(0));
    @(negedge clk_i);
    bus.req.ar_valid = 1'b0;
    bus.req.r_ready  = 1'b1;
    repeat (2) @(negedge clk_i);
    check_eq("pre_rst_r_valid", 64'(bus.resp.r_valid), 64'(1));
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_r_valid", 64'(bus.resp.r_valid), 64'(0));
    check_eq("mid_rst_ar_ready", 64'(bus.resp.ar_ready), 64'(0));
    mdl_clear();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check_eq("post_rst_r_valid", 64'(bus.resp.r_valid), 64'(0));
    end
    bus.req.r_ready = 1'b0;
    axi_read(2'd1, 'h18, 0, BurstIncr, 0, rd);
    check_eq("post_rst_mem", rd, 64'h0);
    wd[0] = 64'h0123456789ABCDEF; ws[0] = 8'hFF;
    axi_write(2'd1, 'h18, 0, BurstIncr, 1, 1'b0);
    axi_read(2'd1, 'h18, 0, BurstIncr, 0, rd);
    check_eq("post_rst_rd", rd, 64'h0123456789ABCDEF);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      addr  = $urandom_range(0, 263) * 8;
      len   = $urandom_range(0, 7);
      burst = ($urandom_range(0, 1) == 0) ? BurstFixed : BurstIncr;
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= len; i++) begin
          wd[i] = {$urandom, $urandom};
          ws[i] = 8'($urandom_range(0, 255));
        end
        if ($urandom_range(0, 7) == 0) burst = BurstWrap;
        nb = ($urandom_range(0, 7) == 0 && len > 0) ? $urandom_range(1, len) : len + 1;
        axi_write(2'($urandom_range(0, 3)), addr, len, burst, nb, 1'b1);
      end else begin
        axi_read(2'($urandom_range(0, 3)), addr, len, burst, 2, rd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
